// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg
//   Shared constants for the pipelined RV32I(M) control path:
//   - OPCODE_* : inst[6:2] major opcodes recognised by the decoder
//   - ALUOP_*  : ALU operation class handed to the EX-stage ALU control
//   - WB_*     : regwrite_sel encodings (write-back source select)
//   - CTRL_*   : bit indices into the flat control bundle, plus CTRL_W
//   - state_t  : control FSM encodings ST_RUN / ST_MD_BUSY / ST_HALT
//   - ctrl_t   : the control bundle as a packed struct (first field = MSB)
package pipeline_control_pkg;

  localparam int CTRL_W = 15;

  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] OPCODE_OP     = 5'b01100;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

  localparam logic [2:0] ALUOP_ADD    = 3'd0; // address / link arithmetic
  localparam logic [2:0] ALUOP_BRANCH = 3'd1; // compare for branches
  localparam logic [2:0] ALUOP_R      = 3'd2; // funct3/funct7 select (OP)
  localparam logic [2:0] ALUOP_I      = 3'd3; // funct3 select (OP-IMM)
  localparam logic [2:0] ALUOP_LUI    = 3'd4; // pass immediate
  localparam logic [2:0] ALUOP_AUIPC  = 3'd5; // pc + immediate

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Flat bundle layout (matches ctrl_t):
  //   14 branch, 13 memread, 12 memtoreg, 11 memwrite, 10 alusrc,
  //   9 regwrite, 8 jalr_jump, 7 jal_jump, 6:5 regwrite_sel,
  //   4:2 aluop, 1 muldiv, 0 is_div
  localparam int CTRL_MEMREAD = 13;
  localparam int CTRL_MULDIV  = 1;
  localparam int CTRL_IS_DIV  = 0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       jalr_jump;
    logic       jal_jump;
    logic [1:0] regwrite_sel;
    logic [2:0] aluop;
    logic       muldiv;
    logic       is_div;
  } ctrl_t;

endpackage

// File: rtl/pipeline_control_decode.sv
// pipeline_control_decode
//   Purely combinational opcode/funct -> control bundle decoder.
//   Ports:
//     opcode   in  5        inst[6:2]
//     funct3_2 in  1        inst[14]; selects DIV/REM vs MUL within M ops
//     funct7_0 in  1        inst[25]; M-extension selector for OP
//     ctrl     out CTRL_W   decoded bundle; all-zero (bubble) for SYSTEM
//                           and any opcode not in the table
module pipeline_control_decode
  import pipeline_control_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [4:0]        opcode,
  input  logic              funct3_2,
  input  logic              funct7_0,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (opcode)
      OPCODE_LOAD: begin
        c.memread      = 1'b1;
        c.memtoreg     = 1'b1;
        c.alusrc       = 1'b1;
        c.regwrite     = 1'b1;
        c.regwrite_sel = WB_MEM;
        c.aluop        = ALUOP_ADD;
      end
      OPCODE_STORE: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = ALUOP_ADD;
      end
      OPCODE_BRANCH: begin
        c.branch = 1'b1;
        c.aluop  = ALUOP_BRANCH;
      end
      OPCODE_JALR: begin
        c.jalr_jump    = 1'b1;
        c.alusrc       = 1'b1;
        c.regwrite     = 1'b1;
        c.regwrite_sel = WB_PC4;
        c.aluop        = ALUOP_ADD;
      end
      OPCODE_JAL: begin
        c.jal_jump     = 1'b1;
        c.regwrite     = 1'b1;
        c.regwrite_sel = WB_PC4;
        c.aluop        = ALUOP_ADD;
      end
      OPCODE_OP_IMM: begin
        c.alusrc       = 1'b1;
        c.regwrite     = 1'b1;
        c.regwrite_sel = WB_ALU;
        c.aluop        = ALUOP_I;
      end
      OPCODE_OP: begin
        c.regwrite     = 1'b1;
        c.regwrite_sel = WB_ALU;
        c.aluop        = ALUOP_R;
        // With the M extension disabled a MUL/DIV encoding falls through
        // as a plain register-register op.
        if (ENABLE_M && funct7_0) begin
          c.muldiv = 1'b1;
          c.is_div = funct3_2;
        end
      end
      OPCODE_LUI: begin
        c.alusrc       = 1'b1;
        c.regwrite     = 1'b1;
        c.regwrite_sel = WB_IMM;
        c.aluop        = ALUOP_LUI;
      end
      OPCODE_AUIPC: begin
        c.alusrc       = 1'b1;
        c.regwrite     = 1'b1;
        c.regwrite_sel = WB_ALU;
        c.aluop        = ALUOP_AUIPC;
      end
      default: c = '0;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control
//   Registered control path: decodes ID into a bundle and carries it through
//   ID/EX, EX/MEM and MEM/WB; handles load-use stalls, multi-cycle MUL/DIV,
//   redirect squashes and ECALL/EBREAK halt.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     id_opcode/funct3/funct7_0/
//       sys_imm/rs1/rs2/rd            instruction fields in ID
//     ex_redirect                     taken branch / jump resolved in EX
//     id_ex_ctrl, ex_mem_ctrl,
//       mem_wb_ctrl                   registered control bundles
//     id_ex_rd, ex_mem_rd, mem_wb_rd  registered destination registers
//     pc_write_en                     enables PC and IF/ID (combinational)
//     if_id_flush                     zero IF/ID on next edge (combinational)
//     md_busy                         MUL/DIV occupying EX (combinational)
//     halted                          sticky halt flag (registered)
//     dbg_state                       current FSM state (state_t encoding)
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 8,
  parameter bit ENABLE_M    = 1'b1,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_0,
  input  logic              id_sys_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              ex_redirect,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [CTRL_W-1:0] ex_mem_ctrl,
  output logic [CTRL_W-1:0] mem_wb_ctrl,
  output logic [4:0]        id_ex_rd,
  output logic [4:0]        ex_mem_rd,
  output logic [4:0]        mem_wb_rd,
  output logic              pc_write_en,
  output logic              if_id_flush,
  output logic              md_busy,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CTRL_W-1:0] dec_ctrl;

  // ECALL and EBREAK both halt; the immediate bit only distinguishes them
  // for software, not for the pipe.
  logic unused_sys_imm;
  assign unused_sys_imm = id_sys_imm;

  pipeline_control_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .opcode   (id_opcode),
    .funct3_2 (id_funct3[2]),
    .funct7_0 (id_funct7_0),
    .ctrl     (dec_ctrl)
  );

  logic load_use;
  logic sys_halt;
  logic release_md;
  assign load_use = id_ex_ctrl[CTRL_MEMREAD] && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));
  assign sys_halt   = (id_opcode == OPCODE_SYSTEM) && (id_funct3 == 3'b000);
  assign release_md = (state == ST_MD_BUSY) && (cnt == CNT_W'(1));

  // What ID/EX receives when the ID instruction is allowed to issue, shared
  // by RUN and by the MD_BUSY release cycle.
  logic [CTRL_W-1:0] issue_ctrl;
  logic [4:0]        issue_rd;
  state_t            issue_state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  md_cnt;

  always_comb begin
    issue_ctrl  = dec_ctrl;
    issue_rd    = id_rd;
    issue_state = ST_RUN;
    issue_cnt   = '0;
    md_cnt      = dec_ctrl[CTRL_IS_DIV] ? DIV_CNT : MUL_CNT;
    if (sys_halt) begin
      issue_ctrl  = '0;
      issue_rd    = '0;
      issue_state = ST_HALT;
    end else if (dec_ctrl[CTRL_MULDIV] && (md_cnt != '0)) begin
      issue_state = ST_MD_BUSY;
      issue_cnt   = md_cnt;
    end
  end

  always_comb begin
    pc_write_en = 1'b0;
    if_id_flush = 1'b0;
    md_busy     = 1'b0;
    if (rst) begin
      pc_write_en = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if_id_flush = ex_redirect;
          pc_write_en = ex_redirect || !(load_use || sys_halt);
        end
        ST_MD_BUSY: begin
          md_busy = 1'b1;
          // On the release edge the ID instruction moves into ID/EX, so
          // IF/ID must advance with it or it would issue twice.
          pc_write_en = release_md && !sys_halt;
        end
        default: pc_write_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      cnt         <= '0;
      halted      <= 1'b0;
      id_ex_ctrl  <= '0;
      ex_mem_ctrl <= '0;
      mem_wb_ctrl <= '0;
      id_ex_rd    <= '0;
      ex_mem_rd   <= '0;
      mem_wb_rd   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          ex_mem_ctrl <= id_ex_ctrl;
          ex_mem_rd   <= id_ex_rd;
          mem_wb_ctrl <= ex_mem_ctrl;
          mem_wb_rd   <= ex_mem_rd;
          // Redirect outranks load-use: the dependent instruction is being
          // squashed anyway, so no stall is needed.
          if (ex_redirect || load_use) begin
            id_ex_ctrl <= '0;
            id_ex_rd   <= '0;
          end else begin
            id_ex_ctrl <= issue_ctrl;
            id_ex_rd   <= issue_rd;
            state      <= issue_state;
            cnt        <= issue_cnt;
            halted     <= (issue_state == ST_HALT);
          end
        end
        ST_MD_BUSY: begin
          mem_wb_ctrl <= ex_mem_ctrl;
          mem_wb_rd   <= ex_mem_rd;
          if (cnt == CNT_W'(1)) begin
            ex_mem_ctrl <= id_ex_ctrl;
            ex_mem_rd   <= id_ex_rd;
            id_ex_ctrl  <= issue_ctrl;
            id_ex_rd    <= issue_rd;
            state       <= issue_state;
            cnt         <= issue_cnt;
            halted      <= (issue_state == ST_HALT);
          end else begin
            ex_mem_ctrl <= '0;
            ex_mem_rd   <= '0;
            cnt         <= cnt - 1'b1;
          end
        end
        ST_HALT: begin
          // Drain: bubbles enter at ID/EX and push older ops out of the pipe.
          id_ex_ctrl  <= '0;
          id_ex_rd    <= '0;
          ex_mem_ctrl <= id_ex_ctrl;
          ex_mem_rd   <= id_ex_rd;
          mem_wb_ctrl <= ex_mem_ctrl;
          mem_wb_rd   <= ex_mem_rd;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control
//   Directed bench for pipeline_control. A table of decode vectors is
//   streamed through the pipe, then hand-written sequences cover load-use,
//   redirect, MUL/DIV stalls, ENABLE_M=0, ECALL/EBREAK halt and reset
//   during a DIV. Instance u_dut uses MUL_LATENCY=1 / DIV_LATENCY=8;
//   u_dut_nom has ENABLE_M=0 and shares all inputs.
module tb_pipeline_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUT signals ----------------
  logic [4:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_0, id_sys_imm, ex_redirect;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  logic [14:0] id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl;
  logic [4:0]  id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic        pc_write_en, if_id_flush, md_busy, halted;
  logic [1:0]  dbg_state;

  logic [14:0] nm_id_ex_ctrl, nm_ex_mem_ctrl, nm_mem_wb_ctrl;
  logic [4:0]  nm_id_ex_rd, nm_ex_mem_rd, nm_mem_wb_rd;
  logic        nm_pc_write_en, nm_if_id_flush, nm_md_busy, nm_halted;
  logic [1:0]  nm_dbg_state;

  pipeline_control #(.MUL_LATENCY(1), .DIV_LATENCY(8), .ENABLE_M(1'b1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_0(id_funct7_0),
    .id_sys_imm(id_sys_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect),
    .id_ex_ctrl(id_ex_ctrl), .ex_mem_ctrl(ex_mem_ctrl), .mem_wb_ctrl(mem_wb_ctrl),
    .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .pc_write_en(pc_write_en), .if_id_flush(if_id_flush), .md_busy(md_busy),
    .halted(halted), .dbg_state(dbg_state)
  );

  pipeline_control #(.MUL_LATENCY(2), .DIV_LATENCY(8), .ENABLE_M(1'b0), .CNT_W(4)) u_dut_nom (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_0(id_funct7_0),
    .id_sys_imm(id_sys_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect),
    .id_ex_ctrl(nm_id_ex_ctrl), .ex_mem_ctrl(nm_ex_mem_ctrl), .mem_wb_ctrl(nm_mem_wb_ctrl),
    .id_ex_rd(nm_id_ex_rd), .ex_mem_rd(nm_ex_mem_rd), .mem_wb_rd(nm_mem_wb_rd),
    .pc_write_en(nm_pc_write_en), .if_id_flush(nm_if_id_flush), .md_busy(nm_md_busy),
    .halted(nm_halted), .dbg_state(nm_dbg_state)
  );

  // ---------------- constants ----------------
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam logic [1:0] S_RUN = 2'd0, S_BUSY = 2'd1, S_HALT = 2'd2;

  // Field order: branch memread memtoreg memwrite alusrc regwrite jalr jal
  //              regwrite_sel[1:0] aluop[2:0] muldiv is_div
  function automatic logic [14:0] mk(input logic br, mr, mt, mw, as, rw, jr, jl,
                                     input logic [1:0] sel, input logic [2:0] alu,
                                     input logic md, dv);
    return {br, mr, mt, mw, as, rw, jr, jl, sel, alu, md, dv};
  endfunction

  logic [14:0] c_load, c_store, c_branch, c_jalr, c_jal, c_addi, c_add;
  logic [14:0] c_mul, c_div, c_lui, c_auipc;

  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [14:0] exp;
  } vec_t;
  vec_t vecs[14];

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [14:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                       input logic imm, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic redir);
    id_opcode   = op;
    id_funct3   = f3;
    id_funct7_0 = f7;
    id_sys_imm  = imm;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    ex_redirect = redir;
    #1;
  endtask

  task automatic drive_nop();
    drive(OP_OPIMM, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_nop();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- test ----------------
  int busy_cycles;

  initial begin
    c_load   = mk(0, 1, 1, 0, 1, 1, 0, 0, 2'd1, 3'd0, 0, 0);
    c_store  = mk(0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 3'd0, 0, 0);
    c_branch = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd1, 0, 0);
    c_jalr   = mk(0, 0, 0, 0, 1, 1, 1, 0, 2'd2, 3'd0, 0, 0);
    c_jal    = mk(0, 0, 0, 0, 0, 1, 0, 1, 2'd2, 3'd0, 0, 0);
    c_addi   = mk(0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 3'd3, 0, 0);
    c_add    = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 3'd2, 0, 0);
    c_mul    = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 3'd2, 1, 0);
    c_div    = mk(0, 0, 0, 0, 0, 1, 0, 0, 2'd0, 3'd2, 1, 1);
    c_lui    = mk(0, 0, 0, 0, 1, 1, 0, 0, 2'd3, 3'd4, 0, 0);
    c_auipc  = mk(0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 3'd5, 0, 0);

    vecs[0]  = '{OP_LOAD,   3'b010, 1'b0, c_load};
    vecs[1]  = '{OP_STORE,  3'b010, 1'b0, c_store};
    vecs[2]  = '{OP_BRANCH, 3'b000, 1'b0, c_branch};
    vecs[3]  = '{OP_JALR,   3'b000, 1'b0, c_jalr};
    vecs[4]  = '{OP_JAL,    3'b000, 1'b0, c_jal};
    vecs[5]  = '{OP_OPIMM,  3'b000, 1'b0, c_addi};
    vecs[6]  = '{OP_OP,     3'b000, 1'b0, c_add};
    vecs[7]  = '{OP_OP,     3'b100, 1'b0, c_add};   // xor: not a divide
    vecs[8]  = '{OP_OP,     3'b000, 1'b1, c_mul};   // mul, single EX cycle here
    vecs[9]  = '{OP_LUI,    3'b000, 1'b0, c_lui};
    vecs[10] = '{OP_AUIPC,  3'b000, 1'b0, c_auipc};
    vecs[11] = '{OP_SYSTEM, 3'b001, 1'b0, 15'd0};   // csrrw: bubble, no halt
    vecs[12] = '{5'b11111,  3'b000, 1'b0, 15'd0};   // unknown opcode
    vecs[13] = '{5'b00011,  3'b000, 1'b0, 15'd0};   // fence: not in table

    // ---- reset state ----
    rst = 1'b1;
    drive_nop();
    tick();
    tick();
    chk("rst_id_ex_ctrl", id_ex_ctrl, 0);
    chk("rst_ex_mem_ctrl", ex_mem_ctrl, 0);
    chk("rst_mem_wb_ctrl", mem_wb_ctrl, 0);
    chk("rst_rds", {id_ex_rd, ex_mem_rd, mem_wb_rd}, 0);
    chk("rst_pc_write_en", pc_write_en, 1);
    chk("rst_if_id_flush", if_id_flush, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_state", dbg_state, S_RUN);
    rst = 1'b0;
    #1;

    // ---- decode table streamed through the pipe ----
    exp_q.push_back(15'd0);
    exp_q.push_back(15'd0);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b0, 5'd0, 5'd0, 5'(i + 1), 1'b0);
      chk($sformatf("tbl%0d_pc_write_en", i), pc_write_en, 1);
      tick();
      chk($sformatf("tbl%0d_id_ex_ctrl", i), id_ex_ctrl, vecs[i].exp);
      chk($sformatf("tbl%0d_id_ex_rd", i), id_ex_rd, i + 1);
      chk($sformatf("tbl%0d_ex_mem_ctrl", i), ex_mem_ctrl, exp_q[$]);
      chk($sformatf("tbl%0d_mem_wb_ctrl", i), mem_wb_ctrl, exp_q[$-1]);
      chk($sformatf("tbl%0d_md_busy", i), md_busy, 0);
      exp_q.push_back(vecs[i].exp);
      if (exp_q.size() > 2) void'(exp_q.pop_front());
    end

    // ---- load-use: lw x5,0(x1); add x6,x5,x2 ----
    do_reset();
    drive(OP_LOAD, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    chk("lu_id_ex_load", id_ex_ctrl, c_load);
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd5, 5'd2, 5'd6, 1'b0);
    chk("lu_pc_stall", pc_write_en, 0);
    chk("lu_no_flush", if_id_flush, 0);
    tick();
    chk("lu_bubble", id_ex_ctrl, 0);
    chk("lu_ex_mem_load", ex_mem_ctrl, c_load);
    chk("lu_ex_mem_rd", ex_mem_rd, 5);
    chk("lu_pc_resume", pc_write_en, 1);
    tick();
    chk("lu_add_issued", id_ex_ctrl, c_add);
    chk("lu_add_rd", id_ex_rd, 6);
    chk("lu_ex_mem_bubble", ex_mem_ctrl, 0);
    chk("lu_mem_wb_load", mem_wb_ctrl, c_load);
    // dependency through rs2
    drive(OP_LOAD, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd7, 1'b0);
    tick();
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd3, 5'd7, 5'd8, 1'b0);
    chk("lu_rs2_pc_stall", pc_write_en, 0);
    tick();
    chk("lu_rs2_bubble", id_ex_ctrl, 0);
    // rd = x0 never stalls
    drive(OP_LOAD, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd2, 5'd6, 1'b0);
    chk("lu_x0_pc", pc_write_en, 1);
    tick();
    chk("lu_x0_add_issued", id_ex_ctrl, c_add);

    // ---- redirect ----
    do_reset();
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 1'b1);
    chk("redir_flush", if_id_flush, 1);
    chk("redir_pc", pc_write_en, 1);
    tick();
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 1'b0);
    chk("redir_bubble", id_ex_ctrl, 0);
    chk("redir_ex_mem_add", ex_mem_ctrl, c_add);
    chk("redir_flush_clear", if_id_flush, 0);
    // redirect and load-use together: redirect wins, no stall
    drive(OP_LOAD, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5, 1'b0);
    tick();
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd5, 5'd2, 5'd6, 1'b1);
    chk("redir_lu_pc", pc_write_en, 1);
    chk("redir_lu_flush", if_id_flush, 1);
    tick();
    drive_nop();
    chk("redir_lu_bubble", id_ex_ctrl, 0);
    chk("redir_lu_state", dbg_state, S_RUN);

    // ---- div x3,x1,x2 with DIV_LATENCY=8 ----
    do_reset();
    drive(OP_OP, 3'b100, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    chk("div_id_ex", id_ex_ctrl, c_div);
    chk("div_state_busy", dbg_state, S_BUSY);
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd10, 5'd11, 5'd12, 1'b0);
    busy_cycles = 0;
    while (md_busy && busy_cycles < 20) begin
      // a redirect while busy must be ignored
      ex_redirect = (busy_cycles == 2);
      #1;
      chk($sformatf("div_c%0d_ex_mem_bubble", busy_cycles), ex_mem_ctrl, 0);
      chk($sformatf("div_c%0d_id_ex_hold", busy_cycles), id_ex_ctrl, c_div);
      chk($sformatf("div_c%0d_pc", busy_cycles), pc_write_en, (busy_cycles == 6) ? 1 : 0);
      chk($sformatf("div_c%0d_flush", busy_cycles), if_id_flush, 0);
      tick();
      busy_cycles++;
    end
    ex_redirect = 1'b0;
    #1;
    chk("div_busy_cycles", busy_cycles, 7);
    chk("div_ex_mem", ex_mem_ctrl, c_div);
    chk("div_ex_mem_rd", ex_mem_rd, 3);
    chk("div_next_issued", id_ex_ctrl, c_add);
    chk("div_next_rd", id_ex_rd, 12);
    chk("div_state_run", dbg_state, S_RUN);

    // ---- mul with MUL_LATENCY=1 / ENABLE_M=0 ----
    do_reset();
    drive(OP_OP, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd4, 1'b0);
    tick();
    drive_nop();
    chk("mul1_id_ex", id_ex_ctrl, c_mul);
    chk("mul1_md_busy", md_busy, 0);
    chk("mul1_pc", pc_write_en, 1);
    chk("nom_mul_id_ex", nm_id_ex_ctrl, c_add);
    chk("nom_mul_md_busy", nm_md_busy, 0);
    chk("nom_mul_pc", nm_pc_write_en, 1);
    tick();
    chk("mul1_ex_mem", ex_mem_ctrl, c_mul);

    // ---- ecall preceded by two adds ----
    do_reset();
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b0);
    tick();
    drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd2, 1'b0);
    tick();
    drive(OP_SYSTEM, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("ecall_pc", pc_write_en, 0);
    tick();
    chk("ecall_halted", halted, 1);
    chk("ecall_state", dbg_state, S_HALT);
    chk("ecall_id_ex_bubble", id_ex_ctrl, 0);
    chk("ecall_mem_wb_add1", {mem_wb_ctrl, mem_wb_rd}, {c_add, 5'd1});
    tick();
    chk("ecall_mem_wb_add2", {mem_wb_ctrl, mem_wb_rd}, {c_add, 5'd2});
    chk("ecall_ex_mem_empty", ex_mem_ctrl, 0);
    for (int k = 0; k < 3; k++) begin
      drive(OP_OP, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9, k[0]);
      chk($sformatf("halt%0d_pc", k), pc_write_en, 0);
      tick();
      chk($sformatf("halt%0d_halted", k), halted, 1);
      chk($sformatf("halt%0d_id_ex", k), id_ex_ctrl, 0);
    end
    chk("halt_drained", mem_wb_ctrl, 0);
    rst = 1'b1;
    drive_nop();
    tick();
    rst = 1'b0;
    #1;
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_pc", pc_write_en, 1);
    chk("halt_rst_state", dbg_state, S_RUN);

    // ---- ebreak also halts ----
    drive(OP_SYSTEM, 3'b000, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("ebreak_pc", pc_write_en, 0);
    tick();
    chk("ebreak_halted", halted, 1);

    // ---- rst at cnt=4 during a div ----
    do_reset();
    drive(OP_OP, 3'b110, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);  // rem
    tick();                                                      // cnt=7
    drive_nop();
    tick();                                                      // cnt=6
    tick();                                                      // cnt=5
    tick();                                                      // cnt=4
    chk("mdrst_still_busy", md_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mdrst_ctrls", {id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl}, 0);
    chk("mdrst_rds", {id_ex_rd, ex_mem_rd, mem_wb_rd}, 0);
    chk("mdrst_state", dbg_state, S_RUN);
    chk("mdrst_pc", pc_write_en, 1);
    chk("mdrst_md_busy", md_busy, 0);
    chk("mdrst_halted", halted, 0);
    tick();
    chk("mdrst_resume", id_ex_ctrl, c_addi);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
